// File: rtl/yutorina_gpr_context_sequencer_if.sv
// rtl/yutorina_gpr_context_sequencer_if.sv - save/restore word streams of the GPR context sequencer
interface yutorina_gpr_context_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (
    output out_valid, out_data, in_ready,
    input  out_ready, in_valid, in_data
  );

  modport slave (
    input  out_valid, out_data, in_ready,
    output out_ready, in_valid, in_data
  );
endinterface

// File: rtl/yutorina_gpr_context_sequencer.sv
// rtl/yutorina_gpr_context_sequencer.sv - bulk GPR save/restore engine for context switch
module yutorina_gpr_context_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  save_req,
  input  logic                  restore_req,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] gpr_read_address,
  input  logic [DATA_WIDTH-1:0] gpr_read_data,
  output logic                  gpr_write_enable_,
  output logic [ADDR_WIDTH-1:0] gpr_write_address,
  output logic [DATA_WIDTH-1:0] gpr_write_data,
  yutorina_gpr_context_sequencer_if.master strm
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_DRAIN,
    S_RESTORE,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] IDX_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = ADDR_WIDTH'(REG_NUM - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  in_ready_q, in_ready_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        idx_d = IDX_FIRST;
        if (save_req) begin
          state_d = S_SAVE;
        end else if (restore_req) begin
          state_d = S_RESTORE;
        end
      end
      S_SAVE: begin
        // The output register takes a new word whenever its current word leaves (or it is empty).
        if (!out_valid_q || strm.out_ready) begin
          out_valid_d = 1'b1;
          out_data_d  = gpr_read_data;
          if (idx_q == IDX_LAST) begin
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + IDX_FIRST;
          end
        end
      end
      S_DRAIN: begin
        if (out_valid_q && strm.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_RESTORE: begin
        if (strm.in_valid) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_FIRST;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Status outputs are registered from the next state so they line up with state_q.
    busy_d     = (state_d == S_SAVE) || (state_d == S_DRAIN) || (state_d == S_RESTORE);
    done_d     = (state_d == S_DONE);
    in_ready_d = (state_d == S_RESTORE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= IDX_FIRST;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign strm.out_valid    = out_valid_q;
  assign strm.out_data     = out_data_q;
  assign strm.in_ready     = in_ready_q;
  assign gpr_read_address  = (state_q == S_SAVE) ? idx_q : '0;
  assign gpr_write_address = (state_q == S_RESTORE) ? idx_q : '0;
  assign gpr_write_enable_ = !(in_ready_q && strm.in_valid);
  assign gpr_write_data    = strm.in_data;

endmodule

// File: tb/tb_yutorina_gpr_context_sequencer.sv
// tb/tb_yutorina_gpr_context_sequencer.sv - scoreboard bench for the GPR context sequencer
module tb_yutorina_gpr_context_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        save_req;
  logic        restore_req;
  logic        busy;
  logic        done;
  logic [4:0]  gpr_read_address;
  logic [31:0] gpr_read_data;
  logic        gpr_write_enable_;
  logic [4:0]  gpr_write_address;
  logic [31:0] gpr_write_data;

  yutorina_gpr_context_sequencer_if #(.DATA_WIDTH(32)) strm ();

  yutorina_gpr_context_sequencer #(
    .DATA_WIDTH(32),
    .REG_NUM   (32),
    .ADDR_WIDTH(5)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .save_req         (save_req),
    .restore_req      (restore_req),
    .busy             (busy),
    .done             (done),
    .gpr_read_address (gpr_read_address),
    .gpr_read_data    (gpr_read_data),
    .gpr_write_enable_(gpr_write_enable_),
    .gpr_write_address(gpr_write_address),
    .gpr_write_data   (gpr_write_data),
    .strm             (strm.master)
  );

  always #5 clock = ~clock;

  logic [31:0] gpr [0:31];
  logic [31:0] orig [0:31];
  logic [31:0] rest_words [1:31];
  logic [31:0] exp_out [$];
  logic [31:0] cap [$];
  int          exp_wr_a [$];
  logic [31:0] exp_wr_d [$];
  int          recv_cnt;
  int          n_pass = 0;
  int          n_total = 0;

  assign gpr_read_data = gpr[gpr_read_address];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Save-stream monitor: ordered scoreboard plus hold-while-stalled rule.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  always @(negedge clock) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("stall_hold", {strm.out_valid, strm.out_data}, {1'b1, prev_data});
      if (strm.out_valid && strm.out_ready) begin
        if (exp_out.size() == 0) check("extra_word", exp_out.size(), 1);
        else check("save_word", strm.out_data, exp_out.pop_front());
        cap.push_back(strm.out_data);
        recv_cnt++;
      end
      prev_hold = strm.out_valid && !strm.out_ready;
      prev_data = strm.out_data;
    end
  end

  // Restore-write monitor: writes happen exactly on handshakes, in register order.
  always @(negedge clock) begin
    if (!reset && (!gpr_write_enable_ || (strm.in_valid && strm.in_ready))) begin
      check("we_vs_handshake", !gpr_write_enable_, strm.in_valid && strm.in_ready);
      if (!gpr_write_enable_) begin
        if (exp_wr_a.size() == 0) begin
          check("extra_write", exp_wr_a.size(), 1);
        end else begin
          check("write_addr", gpr_write_address, exp_wr_a.pop_front());
          check("write_data", gpr_write_data, exp_wr_d.pop_front());
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_out_valid"}, strm.out_valid, 0);
    check({tag, "_out_data"}, strm.out_data, 0);
    check({tag, "_in_ready"}, strm.in_ready, 0);
    check({tag, "_we_n"}, gpr_write_enable_, 1);
    check({tag, "_raddr"}, gpr_read_address, 0);
    check({tag, "_waddr"}, gpr_write_address, 0);
  endtask

  function automatic logic ready_pat(input int mode, input int i);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (i % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_save(input int mode, input bit both, input bit pulse_restore, input int stop_after);
    int cyc;
    bit got_done;
    bit saw_ir;
    exp_out.delete();
    cap.delete();
    recv_cnt = 0;
    for (int k = 1; k < 32; k++) exp_out.push_back(gpr[k]);
    strm.out_ready = ready_pat(mode, 0);
    @(posedge clock); #1;
    save_req = 1'b1;
    restore_req = both;
    @(posedge clock); #1;
    save_req = 1'b0;
    restore_req = 1'b0;
    check("save_busy", busy, 1);
    check("valid_not_yet", strm.out_valid, 0);
    @(posedge clock); #1;
    check("first_valid_latency", strm.out_valid, 1);
    cyc = 0;
    got_done = 0;
    saw_ir = 0;
    while (cyc < 2000) begin
      if (strm.in_ready) saw_ir = 1;
      if (done) begin
        got_done = 1;
        break;
      end
      if (stop_after >= 0 && recv_cnt >= stop_after) break;
      strm.out_ready = ready_pat(mode, cyc + 1);
      if (pulse_restore) restore_req = (cyc == 4);
      @(posedge clock); #1;
      cyc++;
    end
    restore_req = 1'b0;
    if (stop_after >= 0) begin
      check("words_before_reset", recv_cnt, stop_after);
      reset = 1'b1;
      strm.out_ready = 1'b0;
      @(posedge clock); #1;
      check_reset_vals("midreset");
      reset = 1'b0;
      exp_out.delete();
      return;
    end
    check("save_done_seen", got_done, 1);
    check("save_word_count", recv_cnt, 31);
    check("save_queue_empty", exp_out.size(), 0);
    check("in_ready_during_save", saw_ir, 0);
    if (mode == 0) check("save_throughput_cycles", cyc, 31);
    @(posedge clock); #1;
    check("done_one_cycle", done, 0);
    check("idle_after_save", busy, 0);
    if (pulse_restore) begin
      saw_ir = 0;
      for (int i = 0; i < 3; i++) begin
        if (busy || strm.in_ready) saw_ir = 1;
        @(posedge clock); #1;
      end
      check("restore_req_not_queued", saw_ir, 0);
    end
  endtask

  task automatic run_restore(input int gap_pct);
    int  n;
    int  cyc;
    bit  fire;
    bit  got_done;
    bit  wr;
    int  wa;
    logic [31:0] wd;
    exp_wr_a.delete();
    exp_wr_d.delete();
    for (int k = 1; k < 32; k++) begin
      exp_wr_a.push_back(k);
      exp_wr_d.push_back(rest_words[k]);
    end
    @(posedge clock); #1;
    restore_req = 1'b1;
    @(posedge clock); #1;
    restore_req = 1'b0;
    check("restore_in_ready", strm.in_ready, 1);
    check("restore_busy", busy, 1);
    n = 1;
    cyc = 0;
    got_done = 0;
    while (cyc < 3000) begin
      if (done) begin
        got_done = 1;
        break;
      end
      strm.in_valid = (n <= 31) && ($urandom_range(0, 99) >= gap_pct);
      strm.in_data = (n <= 31) ? rest_words[n] : $urandom;
      @(negedge clock);
      fire = strm.in_valid && strm.in_ready;
      wr = !gpr_write_enable_;
      wa = int'(gpr_write_address);
      wd = gpr_write_data;
      @(posedge clock);
      if (wr) gpr[wa] = wd;
      #1;
      if (fire) n++;
      cyc++;
    end
    strm.in_valid = 1'b0;
    check("restore_done_seen", got_done, 1);
    check("restore_word_count", n, 32);
    check("restore_queue_empty", exp_wr_a.size(), 0);
    @(posedge clock); #1;
    check("restore_in_ready_off", strm.in_ready, 0);
    check("idle_after_restore", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    save_req = 1'b0;
    restore_req = 1'b0;
    strm.out_ready = 1'b0;
    strm.in_valid = 1'b0;
    strm.in_data = '0;
    recv_cnt = 0;
    gpr[0] = '0;
    for (int k = 1; k < 32; k++) gpr[k] = 32'h1000_0000 + k;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    // Test 1: ordered save at full rate
    run_save(0, 1'b0, 1'b0, -1);
    check("first_saved", cap[0], 32'h1000_0001);
    check("last_saved", cap[30], 32'h1000_001F);

    // Test 2: stalling consumer
    run_save(1, 1'b0, 1'b0, -1);

    // Test 4: simultaneous requests and ignored mid-save restore_req
    run_save(2, 1'b1, 1'b1, -1);

    // Test 5: reset mid-save, then restart from $1
    run_save(2, 1'b0, 1'b0, 10);
    run_save(0, 1'b0, 1'b0, -1);
    check("restart_first", cap[0], gpr[1]);

    // Test 3: restore with input gaps
    for (int k = 1; k < 32; k++) rest_words[k] = 32'hA500_0000 + k;
    run_restore(50);
    for (int k = 1; k < 32; k++) check("restored_gpr", gpr[k], 32'hA500_0000 + k);
    check("gpr0_zero", gpr[0], 0);

    // Test 6: round trip through a random save and corrupted file
    for (int k = 1; k < 32; k++) gpr[k] = $urandom;
    for (int k = 0; k < 32; k++) orig[k] = gpr[k];
    run_save(2, 1'b0, 1'b0, -1);
    for (int k = 1; k < 32; k++) begin
      rest_words[k] = (cap.size() >= k) ? cap[k-1] : 32'hDEAD_BEEF;
      gpr[k] = ~orig[k];
    end
    run_restore(30);
    for (int k = 0; k < 32; k++) check("round_trip_gpr", gpr[k], orig[k]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
